// File: rtl/arb_rr4_sched_pkg.sv
// Shared types and constants for the four-lane round-robin scheduler.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package arb_rr4_sched_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    // Round-robin pick: first non-empty lane after last_grant, wrapping.
    // If nothing is non-empty the result is last_grant; callers gate on that.
    function automatic logic [LANE_W-1:0] rr_pick(input logic [LANE_W-1:0]    last,
                                                  input logic [NUM_LANES-1:0] ne);
        logic [LANE_W-1:0] pick;
        logic [LANE_W-1:0] cand;
        logic              found;
        pick  = last;
        cand  = last;
        found = 1'b0;
        for (int i = 1; i <= NUM_LANES; i++) begin
            cand = last + LANE_W'(i);
            if (!found && ne[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/arb_rr4_sched_lane_fifo.sv
// Per-lane word FIFO with sticky overflow flag and almost-full indication.
// Latency: a pushed word is visible at head after one edge; head is combinational from storage.
// Backpressure: push on full without same-cycle pop drops the word and latches overflow.
module lane_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int AFULL_TH   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic              almost_full,
    output logic              overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              do_push;
    logic              do_pop;

    // Flags come only from registered occupancy, never from this cycle's inputs.
    assign full        = (count == CNT_W'(FIFO_DEPTH));
    assign empty       = (count == '0);
    assign almost_full = (count >= CNT_W'(AFULL_TH));
    assign head        = mem[rd_ptr];

    // A pop frees the slot this cycle, so a full FIFO may still accept a push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer, occupancy and sticky overflow tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !do_push) overflow <= 1'b1;
        end
    end

    // Word storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/arb_rr4_sched.sv
// Four-lane buffered round-robin scheduler issuing one word per cycle downstream.
// Latency: word pushed at edge k into an idle scheduler appears on dataout after edge k+1.
// Backpressure: pause_in=1 blocks issue that cycle; lanes keep buffering, dropping into overflow_err when full.
module arb_rr4_sched
    import arb_rr4_sched_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int AFULL_TH   = 3
) (
    input  logic              clk_4f,
    input  logic              reset_L,
    input  logic              valid0,
    input  logic              valid1,
    input  logic              valid2,
    input  logic              valid3,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic [DATA_W-1:0] data_in2,
    input  logic [DATA_W-1:0] data_in3,
    input  logic              pause_in,
    output logic              almost_full0,
    output logic              almost_full1,
    output logic              almost_full2,
    output logic              almost_full3,
    output logic [3:0]        overflow_err,
    output logic              validout,
    output logic [DATA_W-1:0] dataout,
    output logic [1:0]        lane_sel,
    output logic              idle
);

    logic [NUM_LANES-1:0] lane_vld;
    logic [NUM_LANES-1:0] lane_empty;
    logic [NUM_LANES-1:0] lane_afull;
    logic [NUM_LANES-1:0] lane_ovf;
    logic [NUM_LANES-1:0] lane_pop;
    logic [DATA_W-1:0]    lane_din  [NUM_LANES];
    logic [DATA_W-1:0]    lane_head [NUM_LANES];

    state_t            state;
    state_t            state_next;
    logic [LANE_W-1:0] last_grant;
    logic [LANE_W-1:0] grant;
    logic              any_ne;
    logic              pop_en;

    assign lane_vld    = {valid3, valid2, valid1, valid0};
    assign lane_din[0] = data_in0;
    assign lane_din[1] = data_in1;
    assign lane_din[2] = data_in2;
    assign lane_din[3] = data_in3;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lane_fifo #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH),
            .AFULL_TH   (AFULL_TH)
        ) u_fifo (
            .clk         (clk_4f),
            .rst_n       (reset_L),
            .push        (lane_vld[g]),
            .push_data   (lane_din[g]),
            .pop         (lane_pop[g]),
            .head        (lane_head[g]),
            .empty       (lane_empty[g]),
            .almost_full (lane_afull[g]),
            .overflow    (lane_ovf[g])
        );
    end

    assign any_ne       = (lane_empty != '1);
    assign grant        = rr_pick(last_grant, ~lane_empty);
    assign almost_full0 = lane_afull[0];
    assign almost_full1 = lane_afull[1];
    assign almost_full2 = lane_afull[2];
    assign almost_full3 = lane_afull[3];
    assign overflow_err = lane_ovf;
    assign idle         = !any_ne && !validout;

    // Next-state logic. A pop is issued in the same cycle the FSM commits to RUN,
    // so leaving IDLE or HOLD costs no extra cycle of latency.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (any_ne && !pause_in) state_next = ST_RUN;
            ST_RUN: begin
                if (pause_in)     state_next = ST_HOLD;
                else if (!any_ne) state_next = ST_IDLE;
            end
            ST_HOLD: if (!pause_in) state_next = any_ne ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Entering or staying in RUN implies pause_in=0 and at least one lane holds data.
    always_comb begin
        pop_en   = (state_next == ST_RUN);
        lane_pop = '0;
        if (pop_en) lane_pop[grant] = 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Registered issue path; dataout/lane_sel hold their last value between words.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            validout   <= 1'b0;
            dataout    <= '0;
            lane_sel   <= '0;
            last_grant <= LANE_W'(NUM_LANES - 1);
        end else begin
            validout <= pop_en;
            if (pop_en) begin
                dataout    <= lane_head[grant];
                lane_sel   <= grant;
                last_grant <= grant;
            end
        end
    end

endmodule

// File: tb/tb_arb_rr4_sched.sv
// Self-checking bench for arb_rr4_sched: directed scenarios with an output scoreboard.
// Latency: n/a.
// Backpressure: exercised through pause_in and lane overflow scenarios.
module tb_arb_rr4_sched;

    logic       clk_4f = 1'b0;
    logic       reset_L;
    logic       valid0, valid1, valid2, valid3;
    logic [7:0] data_in0, data_in1, data_in2, data_in3;
    logic       pause_in;
    logic       almost_full0, almost_full1, almost_full2, almost_full3;
    logic [3:0] overflow_err;
    logic       validout;
    logic [7:0] dataout;
    logic [1:0] lane_sel;
    logic       idle;

    int total = 0;
    int bad   = 0;

    // Expected issued words as {lane, data}, in issue order.
    logic [9:0] exp_q [$];

    arb_rr4_sched dut (
        .clk_4f       (clk_4f),
        .reset_L      (reset_L),
        .valid0       (valid0),
        .valid1       (valid1),
        .valid2       (valid2),
        .valid3       (valid3),
        .data_in0     (data_in0),
        .data_in1     (data_in1),
        .data_in2     (data_in2),
        .data_in3     (data_in3),
        .pause_in     (pause_in),
        .almost_full0 (almost_full0),
        .almost_full1 (almost_full1),
        .almost_full2 (almost_full2),
        .almost_full3 (almost_full3),
        .overflow_err (overflow_err),
        .validout     (validout),
        .dataout      (dataout),
        .lane_sel     (lane_sel),
        .idle         (idle)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_4f);
        #1;
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        #3;
        reset_L = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk(tag, exp_q.size(), 0);
    endtask

    // Scoreboard: every issued word must be the next expected one.
    always @(negedge clk_4f) begin
        if (reset_L === 1'b1 && validout === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {22'd0, lane_sel, dataout}, 32'h3ff);
            end else begin
                chk("sb_word", {22'd0, lane_sel, dataout}, {22'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic expv;
        reset_L  = 1'b1;
        {valid0, valid1, valid2, valid3} = '0;
        {data_in0, data_in1, data_in2, data_in3} = '0;
        pause_in = 1'b0;
        #1 reset_L = 1'b0;
        #2;
        chk("rst_validout", validout, 0);
        chk("rst_dataout", dataout, 0);
        chk("rst_lane_sel", lane_sel, 0);
        chk("rst_ovf", overflow_err, 0);
        chk("rst_afull", {almost_full3, almost_full2, almost_full1, almost_full0}, 0);
        chk("rst_idle", idle, 1);
        tick();
        reset_L = 1'b1;

        // Single word, two-edge latency.
        valid0 = 1'b1; data_in0 = 8'hA5;
        exp_q.push_back({2'd0, 8'hA5});
        tick();
        valid0 = 1'b0;
        chk("lat_early", validout, 0);
        tick();
        chk("lat_vld", validout, 1);
        chk("lat_data", dataout, 8'hA5);
        chk("lat_lane", lane_sel, 0);
        chk("lat_idle_busy", idle, 0);
        tick();
        chk("lat_after", validout, 0);
        chk("lat_idle", idle, 1);

        // Four lanes at once, served 0..3 back to back.
        do_reset();
        {valid3, valid2, valid1, valid0} = 4'hF;
        data_in0 = 8'h10; data_in1 = 8'h20; data_in2 = 8'h30; data_in3 = 8'h40;
        for (int l = 0; l < 4; l++) exp_q.push_back({2'(l), 8'(8'h10 * (l + 1))});
        tick();
        {valid3, valid2, valid1, valid0} = 4'h0;
        for (int l = 0; l < 4; l++) begin
            tick();
            chk("rr4_vld", validout, 1);
            chk("rr4_lane", lane_sel, l);
        end
        tick();
        chk("rr4_end", validout, 0);
        drain("rr4_drain");

        // Overflow on lane 2 while paused.
        do_reset();
        pause_in = 1'b1;
        for (int w = 0; w < 5; w++) begin
            valid2 = 1'b1; data_in2 = 8'(8'h51 + w);
            if (w < 4) exp_q.push_back({2'd2, 8'(8'h51 + w)});
            tick();
            chk("ovf_afull2", almost_full2, (w >= 2) ? 1 : 0);
            chk("ovf_paused", validout, 0);
        end
        valid2 = 1'b0;
        chk("ovf_flag", overflow_err, 4'b0100);
        pause_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ovf_out_vld", validout, 1);
        end
        tick();
        chk("ovf_out_end", validout, 0);
        chk("ovf_sticky", overflow_err, 4'b0100);
        drain("ovf_drain");

        // Lanes 0 and 3 continuously valid: strict alternation.
        do_reset();
        for (int j = 0; j < 6; j++) begin
            valid0 = 1'b1; valid3 = 1'b1;
            data_in0 = 8'(8'h60 + j); data_in3 = 8'(8'h90 + j);
            exp_q.push_back({2'd0, 8'(8'h60 + j)});
            exp_q.push_back({2'd3, 8'(8'h90 + j)});
            tick();
        end
        valid0 = 1'b0; valid3 = 1'b0;
        drain("alt_drain");
        chk("alt_no_ovf", overflow_err, 0);

        // Pause toggling every cycle with lane 1 full.
        do_reset();
        pause_in = 1'b1;
        for (int w = 0; w < 4; w++) begin
            valid1 = 1'b1; data_in1 = 8'(8'h21 + w);
            exp_q.push_back({2'd1, 8'(8'h21 + w)});
            tick();
        end
        valid1 = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            pause_in = (i % 2 == 0) ? 1'b0 : 1'b1;
            expv = !pause_in && (cnt < 4);
            tick();
            chk("tgl_vld", validout, expv);
            if (expv) cnt++;
            else if (cnt > 0) chk("tgl_hold", dataout, 8'(8'h20 + cnt));
        end
        pause_in = 1'b0;
        drain("tgl_drain");

        // Reset mid-stream with three words buffered.
        do_reset();
        valid1 = 1'b1; data_in1 = 8'h77;
        exp_q.push_back({2'd1, 8'h77});
        tick();
        valid1 = 1'b0;
        tick();
        pause_in = 1'b1;
        for (int w = 0; w < 3; w++) begin
            valid1 = 1'b1; data_in1 = 8'(8'hC1 + w);
            tick();
        end
        valid1 = 1'b0;
        chk("mid_hold_data", dataout, 8'h77);
        chk("mid_hold_lane", lane_sel, 1);
        chk("mid_afull1", almost_full1, 1);
        #2 reset_L = 1'b0;
        #1;
        chk("mid_rst_vld", validout, 0);
        chk("mid_rst_data", dataout, 0);
        chk("mid_rst_lane", lane_sel, 0);
        chk("mid_rst_afull1", almost_full1, 0);
        chk("mid_rst_idle", idle, 1);
        tick();
        reset_L = 1'b1;
        pause_in = 1'b0;
        valid2 = 1'b1; data_in2 = 8'h99;
        exp_q.push_back({2'd2, 8'h99});
        tick();
        valid2 = 1'b0;
        tick();
        chk("post_rst_vld", validout, 1);
        drain("post_rst_drain");
        for (int i = 0; i < 4; i++) tick();
        chk("post_rst_quiet", validout, 0);
        chk("post_rst_idle", idle, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arb_rr4_sched.md
ARB_RR4_SCHED -- requirements
Module: arb_rr4_sched

Interface
REQ-001 Parameter DATA_W, default 8, lane and output data width in bits.
REQ-002 Parameter FIFO_DEPTH, default 4, entries per lane FIFO, power of two, 2..16.
REQ-003 Parameter AFULL_TH, default 3, occupancy at or above which almost_fullN asserts.
REQ-004 clk_4f  input  1  sole clock, all state on rising edge.
REQ-005 reset_L  input  1  asynchronous, active-low reset.
REQ-006 valid0..valid3  input  1 each  lane N presents a word this cycle.
REQ-007 data_in0..data_in3  input  DATA_W each  lane N word, sampled when validN=1.
REQ-008 pause_in  input  1  downstream backpressure, 1 = no word may be issued.
REQ-009 almost_full0..almost_full3  output  1 each  lane N occupancy >= AFULL_TH.
REQ-010 overflow_err  output  4  sticky per-lane flag, word dropped on full FIFO.
REQ-011 validout  output  1  dataout/lane_sel carry a word this cycle.
REQ-012 dataout  output  DATA_W  issued word.
REQ-013 lane_sel  output  2  source lane of dataout.
REQ-014 idle  output  1  all FIFOs empty and validout=0.

Function
REQ-015 Each lane SHALL buffer words in its own FIFO_DEPTH-entry FIFO; push when validN=1 and (not full, or full with same-cycle pop of that lane).
REQ-016 Push on full FIFO without same-cycle pop SHALL drop the word and set overflow_err[N], which stays set until reset.
REQ-017 almost_fullN SHALL be combinational from registered occupancy, no input dependence.
REQ-018 FSM states IDLE, RUN, HOLD; IDLE->RUN when any FIFO non-empty and pause_in=0; RUN->HOLD when pause_in=1; HOLD->RUN when pause_in=0 and any non-empty; RUN/HOLD->IDLE when all empty and pause_in=0.
REQ-019 In RUN with pause_in=0, one word per cycle SHALL be popped from the first non-empty lane searching last_grant+1, +2, +3, +4 modulo 4.
REQ-020 last_grant SHALL update only on a pop; reset value 3, so lane 0 has first priority.
REQ-021 dataout, lane_sel, validout SHALL be registered: word popped in cycle k appears after edge k+1 for one cycle.
REQ-022 Latency: word sampled at edge k into an empty FIFO with arbiter idle and pause_in=0 SHALL appear on dataout after edge k+1 (two edges after input valid).
REQ-023 pause_in=1 SHALL block pops that cycle; validout=0 after the next edge; dataout/lane_sel hold last value; pushes continue.
REQ-024 Same-lane push and pop in one cycle SHALL leave occupancy unchanged, including at full and at empty (empty: word is pushed, not bypassed).
REQ-025 Read/write pointers SHALL wrap modulo FIFO_DEPTH; occupancy width clog2(FIFO_DEPTH)+1.
REQ-026 No lane with data SHALL wait more than 3 pops while pause_in=0 (starvation bound).

Reset
REQ-027 reset_L=0 SHALL asynchronously force: FIFOs empty, pointers 0, FSM IDLE, last_grant=3, validout=0, dataout=0, lane_sel=0, overflow_err=0, almost_full*=0, idle=1.
REQ-028 Reset mid-operation SHALL discard all buffered words; first push after release accepted at first rising edge with reset_L=1.

Structure
REQ-029 Shared package/include file SHALL hold FSM state encodings (IDLE=2'b00, RUN=2'b01, HOLD=2'b10) and lane-count constant 4.
REQ-030 One sub-module lane_fifo (parameterised DATA_W, FIFO_DEPTH, AFULL_TH) SHALL be instantiated four times; arbiter and FSM live in arb_rr4_sched.

Verification
REQ-031 Reset release, valid0=1 data_in0=8'hA5 one cycle -> validout=1, dataout=8'hA5, lane_sel=0 after second edge; idle=1 the cycle after.
REQ-032 All four lanes push 8'h10,8'h20,8'h30,8'h40 same cycle -> outputs lanes 0,1,2,3 on four consecutive cycles, validout continuous.
REQ-033 Lane 2 pushes 5 words back-to-back with pause_in=1 (DEPTH 4) -> almost_full2=1 after 3rd, 5th word dropped, overflow_err=4'b0100; release pause -> exactly 4 words out in order.
REQ-034 Lanes 0 and 3 continuously valid -> lane_sel alternates 0,3,0,3; no lane waits >3 pops.
REQ-035 pause_in toggled every cycle with lane 1 full -> validout=1 only after unpaused cycles, FSM RUN/HOLD alternates, order preserved.
REQ-036 reset_L pulsed low mid-stream with 3 words buffered -> outputs immediately at reset values, no buffered word emerges after release.
